blink_period_meter: RTL

//   Receive-side counterpart to the on-board LED blinker. Samples a slow, asynchronous

---
 rtl/blink_period_meter.sv | 103 ++++++++++
 1 files changed

// File: rtl/blink_period_meter.sv
// Measures half-periods of a slow asynchronous toggling input in clk cycles.
// Synchronises and glitch-filters the input and flags an input that stops toggling.
module blink_period_meter #(
  parameter int unsigned CNT_W          = 26,
  parameter int unsigned GLITCH_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 60_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             level,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             stalled
);

  localparam int unsigned      G_W     = $clog2(GLITCH_CYCLES + 1);
  localparam logic [G_W-1:0]   G_LAST  = G_W'(GLITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    MEAS  = 2'd2
  } state_t;

  logic             s1;
  logic             s2;
  logic [G_W-1:0]   g;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             accept_c;

  // The filtered level flips on the last of GLITCH_CYCLES consecutive mismatches.
  assign accept_c = (s2 != level) && (g == G_LAST);

  // Two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      g     <= '0;
    end else if (s2 == level) begin
      g <= '0;
    end else if (g == G_LAST) begin
      level <= s2;
      g     <= '0;
    end else begin
      g <= g + G_W'(1);
    end
  end

  // Cycles since the last accepted edge, saturating so a stalled input never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept_c) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      half_period  <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            state   <= FIRST;
            stalled <= 1'b0;
          end
        end
        FIRST, MEAS: begin
          if (accept_c) begin
            state        <= MEAS;
            half_period  <= cnt;
            period_valid <= 1'b1;
          end else if (cnt == CNT_MAX) begin
            state   <= IDLE;
            stalled <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
